rf_write_scheduler: RTL

Owns the single register-file write port. Shares it between pipeline writeback (WB) and the matrix-multiply result unpacker. Captures the packed 32-bit matrix result C and sequences it as MAT_WORDS byte writes to consecutive registers. Holds a one-entry skid buffer so WB writes that arrive during a burst are not lost, and stalls the pipeline while the port is owned by the matrix burst.

---
 rtl/rf_write_scheduler_pkg.sv | 20 ++
 rtl/rf_write_scheduler_if.sv | 36 +++
 rtl/rf_write_scheduler_skid.sv | 40 ++++
 rtl/rf_write_scheduler.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/rf_write_scheduler_pkg.sv
// Shared types and defaults for the register-file write-port scheduler.
package rf_write_scheduler_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int REG_AW_DEF    = 3;
  localparam int MAT_WORDS_DEF = 4;
  localparam int MAT_BASE_DEF  = 0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MAT_PEND = 2'd1,
    MAT      = 2'd2
  } state_e;

  // Burst counter width; a one-word burst still needs a 1-bit counter.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rf_write_scheduler_if.sv
// WB / matrix / register-file bundle seen by the write scheduler.
interface rf_write_scheduler_if
  import rf_write_scheduler_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int REG_AW    = REG_AW_DEF,
  parameter int MAT_WORDS = MAT_WORDS_DEF
) ();

  logic                        wb_valid;
  logic [REG_AW-1:0]           wb_dest;
  logic [DATA_W-1:0]           wb_data;
  logic                        wb_ready;
  logic                        mat_start;
  logic [DATA_W*MAT_WORDS-1:0] mat_result;
  logic                        mat_busy;
  logic                        mat_done;
  logic                        mat_overrun;
  logic                        rf_we;
  logic [REG_AW-1:0]           rf_waddr;
  logic [DATA_W-1:0]           rf_wdata;
  logic                        pipe_stall;

  modport slave (
    input  wb_valid, wb_dest, wb_data, mat_start, mat_result,
    output wb_ready, mat_busy, mat_done, mat_overrun,
           rf_we, rf_waddr, rf_wdata, pipe_stall
  );

  modport master (
    output wb_valid, wb_dest, wb_data, mat_start, mat_result,
    input  wb_ready, mat_busy, mat_done, mat_overrun,
           rf_we, rf_waddr, rf_wdata, pipe_stall
  );

endinterface

// File: rtl/rf_write_scheduler_skid.sv
// One-entry holding register for a WB write that arrives while the port is busy.
module rf_skid_buffer #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_i,
  input  logic              drain_i,
  input  logic [REG_AW-1:0] dest_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              full_o,
  output logic [REG_AW-1:0] dest_o,
  output logic [DATA_W-1:0] data_o
);

  logic              full_q;
  logic [REG_AW-1:0] dest_q;
  logic [DATA_W-1:0] data_q;

  // Load takes priority; the scheduler never loads and drains in one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_q <= 1'b0;
      dest_q <= '0;
      data_q <= '0;
    end else if (load_i) begin
      full_q <= 1'b1;
      dest_q <= dest_i;
      data_q <= data_i;
    end else if (drain_i) begin
      full_q <= 1'b0;
    end
  end

  assign full_o = full_q;
  assign dest_o = dest_q;
  assign data_o = data_q;

endmodule

// File: rtl/rf_write_scheduler.sv
// Arbitrates the single register-file write port between WB and matrix bursts.
// rf_* is registered: whatever is chosen in a cycle shows on the port next cycle.
// cnt_q holds the index of the matrix byte currently on the port.
module rf_write_scheduler
  import rf_write_scheduler_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int REG_AW    = REG_AW_DEF,
  parameter int MAT_WORDS = MAT_WORDS_DEF,
  parameter int MAT_BASE  = MAT_BASE_DEF
) (
  input logic                clk,
  input logic                reset_n,
  rf_write_scheduler_if.slave bus
);

  localparam int               CNT_W = cnt_w(MAT_WORDS);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(MAT_WORDS - 1);

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [DATA_W*MAT_WORDS-1:0] c_q, c_d;
  logic                        we_q, we_d;
  logic [REG_AW-1:0]           waddr_q, waddr_d;
  logic [DATA_W-1:0]           wdata_q, wdata_d;
  logic                        done_q, done_d, ovr_q, ovr_d;
  logic                        skid_full, skid_load, skid_drain;
  logic [REG_AW-1:0]           skid_dest;
  logic [DATA_W-1:0]           skid_data;
  logic                        wb_acc, mat_busy;

  function automatic logic [REG_AW-1:0] mat_addr(input logic [CNT_W-1:0] idx);
    return REG_AW'(MAT_BASE + int'(idx));
  endfunction

  function automatic logic [DATA_W-1:0] mat_byte(input logic [DATA_W*MAT_WORDS-1:0] c,
                                                 input logic [CNT_W-1:0] idx);
    return c[int'(idx)*DATA_W +: DATA_W];
  endfunction

  rf_skid_buffer #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (skid_load),
    .drain_i (skid_drain),
    .dest_i  (bus.wb_dest),
    .data_i  (bus.wb_data),
    .full_o  (skid_full),
    .dest_o  (skid_dest),
    .data_o  (skid_data)
  );

  assign bus.wb_ready = reset_n & ~skid_full;
  assign wb_acc       = bus.wb_valid & bus.wb_ready;
  assign mat_busy     = reset_n & ((state_q != IDLE) | bus.mat_start);

  // Next-state, port selection and skid control.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    c_d        = c_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    done_d     = 1'b0;
    ovr_d      = ovr_q | (bus.mat_start & (state_q != IDLE));
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Older writes first: a held skid entry, else the live WB write.
        if (skid_full) begin
          we_d = 1'b1; waddr_d = skid_dest; wdata_d = skid_data; skid_drain = 1'b1;
        end else if (wb_acc) begin
          we_d = 1'b1; waddr_d = bus.wb_dest; wdata_d = bus.wb_data;
        end
        if (bus.mat_start) begin
          c_d   = bus.mat_result;
          cnt_d = '0;
          if (we_d) begin
            state_d = MAT_PEND;
          end else begin
            we_d = 1'b1; waddr_d = mat_addr('0); wdata_d = mat_byte(bus.mat_result, '0);
            state_d = MAT;
          end
        end
      end
      MAT_PEND: begin
        skid_load = wb_acc;
        we_d = 1'b1; waddr_d = mat_addr('0); wdata_d = mat_byte(c_q, '0);
        cnt_d   = '0;
        state_d = MAT;
      end
      MAT: begin
        skid_load = wb_acc;
        if (cnt_q == LAST) begin
          // Last byte is on the port now; the skid entry follows it, so it wins.
          cnt_d   = '0;
          state_d = IDLE;
          done_d  = 1'b1;
          if (skid_full) begin
            we_d = 1'b1; waddr_d = skid_dest; wdata_d = skid_data; skid_drain = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          we_d = 1'b1; waddr_d = mat_addr(cnt_d); wdata_d = mat_byte(c_q, cnt_d);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered write port; reset aborts any burst in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      c_q     <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.rf_we       = we_q;
  assign bus.rf_waddr    = waddr_q;
  assign bus.rf_wdata    = wdata_q;
  assign bus.mat_done    = done_q;
  assign bus.mat_overrun = ovr_q;
  assign bus.mat_busy    = mat_busy;
  assign bus.pipe_stall  = mat_busy | skid_full;

endmodule
